mont_redc_256b_64x1: RTL

- Word-serial Montgomery reduction stage. Sits directly downstream of the 256x256 SOS multiplier and consumes its 512-bit product T and completion pulse.
- Computes T·2^-256 mod P with a single shared 64x64 unsigned multiplier.
- Used for four outer iterations (i=0..3), followed by one conditional final subtraction.
- The 256-bit result feeds the SM2 point-arithmetic datapath.

---
 rtl/sm2_pkg.sv | 20 ++
 rtl/mul_64b_wrapper.sv | 10 +
 rtl/mont_redc_256b_64x1.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sm2_pkg.sv
// Shared SM2 field constants, word geometry and the Montgomery reduction FSM encoding.
package sm2_pkg;

  localparam int WORD_W = 64;
  localparam int NWORDS = 4;

  // SM2 prime p; odd, so -p^-1 mod 2^64 exists (it is 1 for this p).
  localparam logic [255:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [63:0]  SM2_N0INV = 64'h0000_0000_0000_0001;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC_M = 3'd1,
    MAC    = 3'd2,
    PROP   = 3'd3,
    SUB    = 3'd4
  } state_t;

endpackage

// File: rtl/mul_64b_wrapper.sv
// 64x64 -> 128 unsigned combinational multiplier shared by the reduction datapath.
module mul_64b_wrapper (
  input  logic [63:0]  i_a,
  input  logic [63:0]  i_b,
  output logic [127:0] o_p
);

  assign o_p = {64'b0, i_a} * {64'b0, i_b};

endmodule

// File: rtl/mont_redc_256b_64x1.sv
// Word-serial Montgomery reduction: R = T * 2^-256 mod P using one shared 64x64 multiplier.
// Four outer iterations (CALC_M, 4x MAC, PROP) then one conditional final subtraction.
//
// Handshake: red_vld_i is a one-cycle start strobe with no ready. It is taken only while
// the FSM is IDLE (including the cycle red_fin_o is high); while busy it is dropped.
// red_t_i is sampled only on the accepting edge. red_fin_o pulses once per accepted job and
// red_r_o holds the result until the next completion.
module mont_redc_256b_64x1
  import sm2_pkg::*;
#(
  parameter logic [255:0] P     = SM2_P,
  parameter logic [63:0]  N0INV = SM2_N0INV
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         red_vld_i,
  input  logic [511:0] red_t_i,
  output logic         red_busy_o,
  output logic         red_fin_o,
  output logic [255:0] red_r_o,
  output state_t       red_dbg_state_o
);

  state_t       r_state;
  logic [63:0]  r_t [0:7];
  logic         r_t8;
  logic [64:0]  r_carry;
  logic [63:0]  r_m;
  logic [1:0]   r_i;
  logic [1:0]   r_j;
  logic         r_busy;
  logic         r_fin;
  logic [255:0] r_r;

  logic [2:0]   w_idx;
  logic [63:0]  w_mul_a;
  logic [63:0]  w_mul_b;
  logic [127:0] w_prod;
  logic [64:0]  w_cin;
  logic [128:0] w_mac;
  logic [256:0] w_hi;
  logic [256:0] w_prop;
  logic         w_ge;
  logic [255:0] w_diff;

  // Word of T touched by the current MAC step.
  assign w_idx = {1'b0, r_i} + {1'b0, r_j};

  // CALC_M multiplies T[i] by N0INV; MAC multiplies m by the j-th word of P.
  assign w_mul_a = (r_state == CALC_M) ? r_t[{1'b0, r_i}] : r_m;
  assign w_mul_b = (r_state == CALC_M) ? N0INV : P[{r_j, 6'b0} +: 64];

  mul_64b_wrapper u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  // Carry chain restarts at j=0 of every outer iteration.
  assign w_cin = (r_j == 2'd0) ? 65'd0 : r_carry;
  assign w_mac = {1'b0, w_prod} + {65'b0, r_t[w_idx]} + {64'b0, w_cin};

  // Upper half {t8,T[7:4]}; the MAC carry lands on word i+4, i.e. i words above word 4.
  assign w_hi   = {r_t8, r_t[7], r_t[6], r_t[5], r_t[4]};
  assign w_prop = w_hi + ({192'b0, r_carry} << {r_i, 6'b0});

  // Final conditional subtraction; U-P fits in 256 bits whenever U >= P.
  assign w_ge   = (w_hi >= {1'b0, P});
  assign w_diff = w_hi[255:0] - P;

  // Reduction FSM with all working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      for (int k = 0; k < 8; k++) r_t[k] <= '0;
      r_t8    <= 1'b0;
      r_carry <= '0;
      r_m     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_busy  <= 1'b0;
      r_fin   <= 1'b0;
      r_r     <= '0;
    end else begin
      r_fin <= 1'b0;
      case (r_state)
        IDLE: begin
          if (red_vld_i) begin
            for (int k = 0; k < 8; k++) r_t[k] <= red_t_i[k*64 +: 64];
            r_t8    <= 1'b0;
            r_carry <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC_M;
          end
        end
        CALC_M: begin
          r_m     <= w_prod[63:0];
          r_j     <= '0;
          r_state <= MAC;
        end
        MAC: begin
          r_t[w_idx] <= w_mac[63:0];
          r_carry    <= w_mac[128:64];
          if (r_j == 2'd3) begin
            r_state <= PROP;
          end else begin
            r_j <= r_j + 2'd1;
          end
        end
        PROP: begin
          {r_t8, r_t[7], r_t[6], r_t[5], r_t[4]} <= w_prop;
          r_carry <= '0;
          if (r_i == 2'd3) begin
            r_state <= SUB;
          end else begin
            r_i     <= r_i + 2'd1;
            r_state <= CALC_M;
          end
        end
        SUB: begin
          r_r     <= w_ge ? w_diff : w_hi[255:0];
          r_fin   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign red_busy_o      = r_busy;
  assign red_fin_o       = r_fin;
  assign red_r_o         = r_r;
  assign red_dbg_state_o = r_state;

endmodule
